// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder
// Brief    : Packs mnemonic + operand requests into 32-bit MIPS words, queues
//            them in a small FIFO and streams them into instruction memory.
//            Optional macro ENC_SHIFT_EN enables the SLL/SRL/SRA codes.
// Revision : 1.0 - initial release
// ============================================================================
module mips_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    input  logic              clr_err,
    output logic              illegal_err,
    output logic              addr_ovf,
    output logic [ADDR_W:0]   wr_count
);

    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL_CNT = DEPTH[c_PTR_W:0];
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   c_CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

    // Mnemonic codes
    localparam logic [4:0] c_OP_ADD  = 5'd0;
    localparam logic [4:0] c_OP_ADDU = 5'd1;
    localparam logic [4:0] c_OP_AND  = 5'd2;
    localparam logic [4:0] c_OP_JALR = 5'd3;
    localparam logic [4:0] c_OP_JR   = 5'd4;
    localparam logic [4:0] c_OP_NOR  = 5'd5;
    localparam logic [4:0] c_OP_OR   = 5'd6;
    localparam logic [4:0] c_OP_SUB  = 5'd7;
    localparam logic [4:0] c_OP_SUBU = 5'd8;
    localparam logic [4:0] c_OP_XOR  = 5'd9;
    localparam logic [4:0] c_OP_ADDI = 5'd10;
    localparam logic [4:0] c_OP_ANDI = 5'd11;
    localparam logic [4:0] c_OP_ORI  = 5'd12;
    localparam logic [4:0] c_OP_XORI = 5'd13;
    localparam logic [4:0] c_OP_SW   = 5'd14;
    localparam logic [4:0] c_OP_LW   = 5'd15;
    localparam logic [4:0] c_OP_MUL  = 5'd16;
    localparam logic [4:0] c_OP_J    = 5'd17;
    localparam logic [4:0] c_OP_JAL  = 5'd18;
`ifdef ENC_SHIFT_EN
    localparam logic [4:0] c_OP_SLL  = 5'd19;
    localparam logic [4:0] c_OP_SRL  = 5'd20;
    localparam logic [4:0] c_OP_SRA  = 5'd21;
`endif

    // Primary opcodes and R-type function codes
    localparam logic [5:0] c_OPC_RTYPE = 6'h00;
    localparam logic [5:0] c_OPC_J     = 6'h02;
    localparam logic [5:0] c_OPC_JAL   = 6'h03;
    localparam logic [5:0] c_OPC_ADDI  = 6'h08;
    localparam logic [5:0] c_OPC_ANDI  = 6'h0C;
    localparam logic [5:0] c_OPC_ORI   = 6'h0D;
    localparam logic [5:0] c_OPC_XORI  = 6'h0E;
    localparam logic [5:0] c_OPC_MUL   = 6'h1C;
    localparam logic [5:0] c_OPC_LW    = 6'h23;
    localparam logic [5:0] c_OPC_SW    = 6'h2B;
    localparam logic [5:0] c_FN_JR     = 6'h08;
    localparam logic [5:0] c_FN_JALR   = 6'h09;
    localparam logic [5:0] c_FN_ADD    = 6'h20;
    localparam logic [5:0] c_FN_ADDU   = 6'h21;
    localparam logic [5:0] c_FN_SUB    = 6'h22;
    localparam logic [5:0] c_FN_SUBU   = 6'h23;
    localparam logic [5:0] c_FN_AND    = 6'h24;
    localparam logic [5:0] c_FN_OR     = 6'h25;
    localparam logic [5:0] c_FN_XOR    = 6'h26;
    localparam logic [5:0] c_FN_NOR    = 6'h27;
    localparam logic [5:0] c_FN_MULW   = 6'h02;
`ifdef ENC_SHIFT_EN
    localparam logic [5:0] c_FN_SLL    = 6'h00;
    localparam logic [5:0] c_FN_SRL    = 6'h02;
    localparam logic [5:0] c_FN_SRA    = 6'h03;
`endif

    function automatic logic [31:0] f_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [5:0] fn);
        return {c_OPC_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] f_itype(input logic [5:0] opc, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    logic [31:0]        w_word;
    logic               w_legal;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;

    logic [31:0]        r_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [ADDR_W:0]    r_wr_count;
    logic               r_addr_ovf;
    logic               r_illegal_err;

`ifndef ENC_SHIFT_EN
    logic w_unused_shamt;
    assign w_unused_shamt = ^in_shamt;
`endif

    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b1;
        case (in_op)
            c_OP_ADD:  w_word = f_rtype(in_rs, in_rt, in_rd, c_FN_ADD);
            c_OP_ADDU: w_word = f_rtype(in_rs, in_rt, in_rd, c_FN_ADDU);
            c_OP_AND:  w_word = f_rtype(in_rs, in_rt, in_rd, c_FN_AND);
            c_OP_JALR: w_word = f_rtype(in_rs, 5'd0,  in_rd, c_FN_JALR);
            c_OP_JR:   w_word = f_rtype(in_rs, 5'd0,  5'd0,  c_FN_JR);
            c_OP_NOR:  w_word = f_rtype(in_rs, in_rt, in_rd, c_FN_NOR);
            c_OP_OR:   w_word = f_rtype(in_rs, in_rt, in_rd, c_FN_OR);
            c_OP_SUB:  w_word = f_rtype(in_rs, in_rt, in_rd, c_FN_SUB);
            c_OP_SUBU: w_word = f_rtype(in_rs, in_rt, in_rd, c_FN_SUBU);
            c_OP_XOR:  w_word = f_rtype(in_rs, in_rt, in_rd, c_FN_XOR);
            c_OP_ADDI: w_word = f_itype(c_OPC_ADDI, in_rs, in_rt, in_imm);
            c_OP_ANDI: w_word = f_itype(c_OPC_ANDI, in_rs, in_rt, in_imm);
            c_OP_ORI:  w_word = f_itype(c_OPC_ORI,  in_rs, in_rt, in_imm);
            c_OP_XORI: w_word = f_itype(c_OPC_XORI, in_rs, in_rt, in_imm);
            c_OP_SW:   w_word = f_itype(c_OPC_SW,   in_rs, in_rt, in_imm);
            c_OP_LW:   w_word = f_itype(c_OPC_LW,   in_rs, in_rt, in_imm);
            c_OP_MUL:  w_word = {c_OPC_MUL, in_rs, in_rt, in_rd, 5'd0, c_FN_MULW};
            c_OP_J:    w_word = {c_OPC_J,   in_target};
            c_OP_JAL:  w_word = {c_OPC_JAL, in_target};
`ifdef ENC_SHIFT_EN
            c_OP_SLL:  w_word = {c_OPC_RTYPE, 5'd0, in_rt, in_rd, in_shamt, c_FN_SLL};
            c_OP_SRL:  w_word = {c_OPC_RTYPE, 5'd0, in_rt, in_rd, in_shamt, c_FN_SRL};
            c_OP_SRA:  w_word = {c_OPC_RTYPE, 5'd0, in_rt, in_rd, in_shamt, c_FN_SRA};
`endif
            default:   w_legal = 1'b0;
        endcase
    end

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL_CNT);
    assign in_ready = !w_full && !r_addr_ovf && !addr_load;
    assign mem_we   = !w_empty && !r_addr_ovf;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    // addr_load suppresses the transfer even though mem_we may be high.
    assign w_pop    = mem_we && mem_ready && !addr_load;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (addr_load) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The last address is written once; afterwards the write port halts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr <= ADDR_W'(BASE_ADDR);
            r_addr_ovf <= 1'b0;
            r_wr_count <= '0;
        end else if (addr_load) begin
            r_mem_addr <= addr_value;
            r_addr_ovf <= 1'b0;
            r_wr_count <= '0;
        end else if (w_pop) begin
            if (r_mem_addr == c_ADDR_MAX) begin
                r_addr_ovf <= 1'b1;
            end else begin
                r_mem_addr <= r_mem_addr + 1'b1;
            end
            if (r_wr_count != c_CNT_MAX) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_err <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_illegal_err <= 1'b1;
        end else if (clr_err) begin
            r_illegal_err <= 1'b0;
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_data    = w_empty ? 32'd0 : r_fifo[r_rd_ptr];
    assign addr_ovf    = r_addr_ovf;
    assign wr_count    = r_wr_count;
    assign illegal_err = r_illegal_err;

endmodule
`default_nettype wire

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Encoder counterpart of the control-unit decoder. Accepts a mnemonic code plus operand fields over a valid/ready handshake and packs them into 32-bit MIPS words (opcode/funct exactly as the decoder expects). Buffers the words in a small FIFO and writes them sequentially into instruction memory through a backpressured write port, so test programs can be loaded at run time.

Parameters:
ADDR_W, 8, instruction-memory word-address width (word addressing, PC+1 convention)
DEPTH, 4, FIFO entries; power of two, at least 2
BASE_ADDR, 0, address counter value after reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  = !fifo_full && !addr_ovf && !addr_load (combinational)
in_op  in  5  mnemonic code: 0 ADD, 1 ADDU, 2 AND, 3 JALR, 4 JR, 5 NOR, 6 OR, 7 SUB, 8 SUBU, 9 XOR, 10 ADDI, 11 ANDI, 12 ORI, 13 XORI, 14 SW, 15 LW, 16 MUL, 17 J, 18 JAL
in_rs / in_rt / in_rd / in_shamt  in  5 each  register and shift fields
in_imm  in  16  immediate / offset
in_target  in  26  jump target
mem_we  out  1  write request = FIFO non-empty && !addr_ovf
mem_ready  in  1  memory accepts the write this cycle
mem_addr  out  ADDR_W  current write address (registered)
mem_data  out  32  FIFO head word
addr_load  in  1  load mem_addr from addr_value, flush FIFO, clear addr_ovf
addr_value  in  ADDR_W  load value
clr_err  in  1  clears illegal_err
illegal_err  out  1  sticky: an unsupported in_op was accepted
addr_ovf  out  1  sticky: the last address 2^ADDR_W-1 was written
wr_count  out  ADDR_W+1  words written since reset/load, saturating

Behaviour:
- Reset: FIFO empty; mem_addr=BASE_ADDR; wr_count=0; illegal_err=0; addr_ovf=0; mem_we=0; mem_data=0.
- Accept happens on a clock edge with in_valid && in_ready. Encoding is combinational and the word is pushed at that edge. mem_we asserts in the next cycle, so accept-to-write-request latency is 1 cycle.
- R-type: opcode 0. Word = {6'h00, rs, rt, rd, 5'd0, funct}. funct values: ADD 20, ADDU 21, AND 24, JALR 09, JR 08, NOR 27, OR 25, SUB 22, SUBU 23, XOR 26 (hex). JR forces rt=rd=0. JALR forces rt=0.
- I-type: {opcode, rs, rt, imm}. Opcodes: ADDI 08, ANDI 0C, ORI 0D, XORI 0E, SW 2B, LW 23 (hex).
- MUL: {6'h1C, rs, rt, rd, 5'd0, 6'h02}.
- J/JAL: {6'h02 or 6'h03, target}.
- Illegal in_op: the handshake completes, nothing is pushed, illegal_err sets. If clr_err and an illegal accept occur in the same cycle, set wins.
- Write transfer happens on an edge with mem_we && mem_ready. The FIFO pops, mem_addr increments, and wr_count increments (saturating at 2^ADDR_W).
- Push and pop in the same cycle are allowed when the FIFO is not full; occupancy is unchanged.
- Full: in_ready=0, and the FIFO head is held stable while mem_ready=0. mem_we, mem_addr and mem_data must not change until the transfer happens.
- Wrap: a transfer at address 2^ADDR_W-1 sets addr_ovf and leaves mem_addr unchanged (no wrap to 0). While addr_ovf=1, mem_we=0 and in_ready=0. Queued words are retained.
- addr_load has highest priority. In that cycle there is no accept and no transfer. At the edge: mem_addr=addr_value, FIFO emptied, addr_ovf=0, wr_count=0.
- Reset asserted mid-operation discards FIFO contents immediately (asynchronous); mem_we drops with reset.
- State view: EMPTY (count=0), QUEUED (0<count<DEPTH), FULL (count=DEPTH), HALT (addr_ovf=1). HALT is left only by addr_load or reset.

Optional Feature:
ENC_SHIFT_EN: when defined, codes 19 SLL, 20 SRL and 21 SRA are legal and encode as {6'h00, 5'd0, rt, rd, shamt, funct}, with funct 00/02/03 (hex). When undefined, codes 19-21 are illegal, like every other code at or above 19.

Test Plan:
- ADD rd=3 rs=1 rt=2 -> mem_we 1 cycle later, mem_addr=0, mem_data=0x00221820; with mem_ready=1, mem_addr becomes 1 and wr_count becomes 1.
- ADDI rt=8 rs=0 imm=5; LW rt=9 rs=29 imm=0xFFFC; J target=0x10; JR rs=31; MUL rd=4 rs=5 rt=6 -> words 0x20080005, 0x8FA9FFFC, 0x08000010, 0x03E00008, 0x70A62002 at consecutive addresses.
- mem_ready held 0 while pushing 5 words with DEPTH=4 -> in_ready drops after the 4th accept and the head word stays stable; release mem_ready -> all 5 words are written in order with no loss.
- in_op=25 -> accepted, no write, illegal_err=1; clr_err -> illegal_err=0.
- addr_load with addr_value=0xFE, then push 3 words -> writes at 0xFE and 0xFF, addr_ovf=1, the 3rd word is held with mem_we=0; addr_load with 0x00 -> flag clears and the FIFO is emptied.
- With ENC_SHIFT_EN, SLL rd=2 rt=3 shamt=4 -> 0x00031100; without the macro the same request sets illegal_err.
